// File: rtl/nand_mod_counter.sv
// nand_mod_counter: modulo up/down counter with load, clamp, optional saturation and terminal count.
// Latency: load and count updates appear one clock after the sampling edge; tc is combinational.
// Backpressure: none; every enabled edge advances the count.
// Optional macro CMOS_SWITCH_LEVEL_EN builds the counter from switch-level pmos/nmos NAND cells.

`ifdef CMOS_SWITCH_LEVEL_EN
module nmc_nand2 (input wire a, input wire b, output wire y);
  supply1 vdd;
  supply0 gnd;
  wire mid;
  pmos p_a (y, vdd, a);
  pmos p_b (y, vdd, b);
  nmos n_a (y, mid, a);
  nmos n_b (mid, gnd, b);
endmodule

module nmc_inv (input wire a, output wire y);
  nmc_nand2 u_n (.a(a), .b(a), .y(y));
endmodule

module nmc_and2 (input wire a, input wire b, output wire y);
  wire n;
  nmc_nand2 u_n (.a(a), .b(b), .y(n));
  nmc_inv   u_i (.a(n), .y(y));
endmodule

module nmc_or2 (input wire a, input wire b, output wire y);
  wire an, bn;
  nmc_inv   u_a (.a(a), .y(an));
  nmc_inv   u_b (.a(b), .y(bn));
  nmc_nand2 u_n (.a(an), .b(bn), .y(y));
endmodule

module nmc_xor2 (input wire a, input wire b, output wire y);
  wire n0, n1, n2;
  nmc_nand2 u0 (.a(a), .b(b), .y(n0));
  nmc_nand2 u1 (.a(a), .b(n0), .y(n1));
  nmc_nand2 u2 (.a(b), .b(n0), .y(n2));
  nmc_nand2 u3 (.a(n1), .b(n2), .y(y));
endmodule

// y = s ? b : a
module nmc_mux2 (input wire a, input wire b, input wire s, output wire y);
  wire sn, n0, n1;
  nmc_inv   u_s (.a(s), .y(sn));
  nmc_nand2 u0 (.a(a), .b(sn), .y(n0));
  nmc_nand2 u1 (.a(b), .b(s), .y(n1));
  nmc_nand2 u2 (.a(n0), .b(n1), .y(y));
endmodule

// Gated SR-NAND latch, transparent while g=1.
module nmc_dlatch (input wire d, input wire g, output wire q);
  wire dn, s, r, qn;
  nmc_inv   u_d (.a(d), .y(dn));
  nmc_nand2 u_s (.a(d), .b(g), .y(s));
  nmc_nand2 u_r (.a(dn), .b(g), .y(r));
  nmc_nand2 u_q (.a(s), .b(qn), .y(q));
  nmc_nand2 u_qn (.a(r), .b(q), .y(qn));
endmodule

// Master open while clk low, slave open while clk high: captures on the rising edge.
module nmc_dff (input wire d, input wire clk, output wire q);
  wire clkn, m;
  nmc_inv    u_c (.a(clk), .y(clkn));
  nmc_dlatch u_m (.d(d), .g(clkn), .q(m));
  nmc_dlatch u_s (.d(m), .g(clk), .q(q));
endmodule
`endif

module nand_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  // Value reached when stepping past each end of the range.
  localparam logic [WIDTH-1:0] UP_END = (SATURATE != 0) ? MAX : '0;
  localparam logic [WIDTH-1:0] DN_END = (SATURATE != 0) ? '0 : MAX;

`ifdef CMOS_SWITCH_LEVEL_EN
  wire [WIDTH-1:0] q, cnt_n, inc, dec, nu, nd, nc, ne, nl, nn, d;
  wire [WIDTH-1:0] max_c  = MAX;
  wire [WIDTH-1:0] up_end = UP_END;
  wire [WIDTH-1:0] dn_end = DN_END;
  wire [WIDTH:0]   carry, borrow, eqm_c, eqz_c, gt_c;
  wire rst_n, up_n, load_n, term_up, term_dn, term, g1, g2;
  wire eq_max  = eqm_c[WIDTH];
  wire eq_zero = eqz_c[WIDTH];
  wire gt      = gt_c[WIDTH];

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;
  assign eqm_c[0]  = 1'b1;
  assign eqz_c[0]  = 1'b1;
  assign gt_c[0]   = 1'b0;

  nmc_inv u_rst_n (.a(rst), .y(rst_n));
  nmc_inv u_up_n (.a(up), .y(up_n));
  nmc_inv u_ld_n (.a(load), .y(load_n));

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      nmc_inv  u_cn (.a(q[i]), .y(cnt_n[i]));
      // Ripple incrementer and decrementer.
      nmc_xor2 u_inc (.a(q[i]), .b(carry[i]), .y(inc[i]));
      nmc_and2 u_cy (.a(q[i]), .b(carry[i]), .y(carry[i+1]));
      nmc_xor2 u_dec (.a(q[i]), .b(borrow[i]), .y(dec[i]));
      nmc_and2 u_bw (.a(cnt_n[i]), .b(borrow[i]), .y(borrow[i+1]));
      nmc_and2 u_ez (.a(eqz_c[i]), .b(cnt_n[i]), .y(eqz_c[i+1]));
      // Compare against the constant top value, LSB first.
      if (MAX[i]) begin : g_m1
        nmc_and2 u_em (.a(eqm_c[i]), .b(q[i]), .y(eqm_c[i+1]));
        nmc_and2 u_gt (.a(load_val[i]), .b(gt_c[i]), .y(gt_c[i+1]));
      end else begin : g_m0
        nmc_and2 u_em (.a(eqm_c[i]), .b(cnt_n[i]), .y(eqm_c[i+1]));
        nmc_or2  u_gt (.a(load_val[i]), .b(gt_c[i]), .y(gt_c[i+1]));
      end
      // Next-state selection: rst > load > en > hold.
      nmc_mux2 u_nu (.a(inc[i]), .b(up_end[i]), .s(eq_max), .y(nu[i]));
      nmc_mux2 u_nd (.a(dec[i]), .b(dn_end[i]), .s(eq_zero), .y(nd[i]));
      nmc_mux2 u_dir (.a(nd[i]), .b(nu[i]), .s(up), .y(nc[i]));
      nmc_mux2 u_en (.a(q[i]), .b(nc[i]), .s(en), .y(ne[i]));
      nmc_mux2 u_clp (.a(load_val[i]), .b(max_c[i]), .s(gt), .y(nl[i]));
      nmc_mux2 u_ld (.a(ne[i]), .b(nl[i]), .s(load), .y(nn[i]));
      nmc_and2 u_rs (.a(nn[i]), .b(rst_n), .y(d[i]));
      nmc_dff  u_ff (.d(d[i]), .clk(clk), .q(q[i]));
    end
  endgenerate

  nmc_and2 u_tu (.a(up), .b(eq_max), .y(term_up));
  nmc_and2 u_td (.a(up_n), .b(eq_zero), .y(term_dn));
  nmc_or2  u_tm (.a(term_up), .b(term_dn), .y(term));
  nmc_and2 u_g1 (.a(en), .b(load_n), .y(g1));
  nmc_and2 u_g2 (.a(g1), .b(rst_n), .y(g2));
  nmc_and2 u_tc (.a(g2), .b(term), .y(tc));

  assign count = q;
`else
  // Counter register: reset, clamped load, then enabled up/down step with wrap or hold at ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        count <= (count == MAX) ? UP_END : count + ONE;
      end else begin
        count <= (count == '0) ? DN_END : count - ONE;
      end
    end
  end

  // Terminal count flags the edge that will wrap or hold at a range end.
  assign tc = ~rst & en & ~load & ((up & (count == MAX)) | (~up & (count == '0)));
`endif

endmodule

// File: doc/nand_mod_counter.md
Name: nand_mod_counter

Overview:
- Parametrised synchronous modulo up/down counter for the cmos cell library; successor to the fixed 2-input NAND cell.
- Adds state: WIDTH-bit register, programmable modulus, load, direction, optional saturation, terminal-count flag.
- Used as a library building block for dividers and sequencers.
- Optionally built entirely from switch-level pmos/nmos NAND structures.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MAX_VAL, 2**WIDTH-1, top count value; counter range is 0..MAX_VAL; must be < 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  registered counter value.
- tc  output  1  terminal count, combinational.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: with rst=1 at a rising edge, count becomes 0. tc follows its equation from count=0. rst overrides all other inputs.
- Priority at each edge: rst > load > en. With none asserted, count holds.
- Load: count becomes load_val at the edge, one-cycle latency. If load_val > MAX_VAL, count becomes MAX_VAL (clamp). load ignores en and up.
- Count up (en=1, up=1, load=0):
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: becomes 0 if SATURATE=0; holds MAX_VAL if SATURATE=1.
- Count down (en=1, up=0, load=0):
  - count > 0: count-1.
  - count == 0: becomes MAX_VAL if SATURATE=0; holds 0 if SATURATE=1.
- tc = en & ~load & ((up & count==MAX_VAL) | (~up & count==0)).
  - Purely combinational from current count and inputs.
  - Asserted in the cycle before the wrap (or hold) edge.
  - Forced 0 while rst=1.
- Arithmetic: all compares and updates are unsigned modulo 2**WIDTH. No intermediate value outside 0..MAX_VAL is ever registered.
- Direction change: up may toggle every cycle; each edge uses the up value sampled at that edge.
- Simultaneous load and en: load wins; count = load_val (clamped); tc = 0.
- Reset mid-count: count is 0 the next cycle regardless of en/load. Counting resumes from 0 on the first edge with rst=0.
- Before the first reset: count is unknown. A bench only checks after reset.
- MAX_VAL=0: count is always 0; tc = en & ~load.

Optional Feature:
- Macro: CMOS_SWITCH_LEVEL_EN
- Defined:
  - Storage built from NAND-based master-slave flip-flops.
  - Next-state logic built from 2-input NAND cells.
  - Both made of pmos/nmos primitives with supply1/supply0 rails.
  - Cycle behaviour identical to the undefined case; the same tests must pass.
- Undefined: behavioural RTL, a single clocked process plus a combinational tc assignment.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0: rst 1 cycle, then en=1, up=1 for 12 cycles -> count 1..9,0,1,2. tc=1 exactly in the cycle with count=9.
- Same config, up=0 from count=0, 3 cycles -> count 9,8,7. tc=1 in the initial count=0 cycle.
- SATURATE=1, MAX_VAL=9: load_val=8, then up 3 cycles -> 8,9,9,9. Then down from 1, 3 cycles -> 0,0,0.
- load=1, en=1, load_val=13, MAX_VAL=9 -> count=9 next cycle and tc=0 during the load cycle. load_val=5 -> count=5.
- Count to 6, assert rst together with load=1, load_val=3 -> count=0 next cycle and tc=0 while rst=1. Deassert rst with en=1, up=1 -> count 1.
- Rebuild with CMOS_SWITCH_LEVEL_EN defined. Rerun all of the above -> cycle-identical count/tc traces versus the behavioural build.
